// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: pipelined AES SubBytes / InvSubBytes engine, LANES bytes per transfer,
// valid/ready on both sides, bubble-collapsing stages and a completed-transfer counter.
// Optional lane parity (in_par check, out_par generation, sticky par_err) is built when
// the macro AES_SBOX_PIPE_PARITY_EN is defined.
module aes_sbox_pipe #(
  parameter int LANES = 4,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
`ifdef AES_SBOX_PIPE_PARITY_EN
  input  logic [LANES-1:0]   in_par,
  output logic [LANES-1:0]   out_par,
  output logic               par_err,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inv,
  output logic [8*LANES-1:0] out_data,
  output logic [CNT_W-1:0]   done_cnt,
  input  logic               clr_cnt
);

  localparam int W = 8 * LANES;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero naturally maps to zero
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x6   = gfMul(x3, x3);
    x12  = gfMul(x6, x6);
    x15  = gfMul(x12, x3);
    x30  = gfMul(x15, x15);
    x60  = gfMul(x30, x30);
    x120 = gfMul(x60, x60);
    x240 = gfMul(x120, x120);
    x252 = gfMul(x240, x12);
    return gfMul(x252, x2);
  endfunction

  function automatic logic [7:0] affineFwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affineInv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // Front half: inverse mode applies the inverse affine first, both modes then invert
  function automatic logic [W-1:0] frontWord(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = gfInv(inv ? affineInv(d[8*i +: 8]) : d[8*i +: 8]);
    end
    return r;
  endfunction

  // Back half: forward mode finishes with the affine map, inverse mode is already done
  function automatic logic [W-1:0] backWord(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = inv ? d[8*i +: 8] : affineFwd(d[8*i +: 8]);
    end
    return r;
  endfunction

  logic [PIPE-1:0] stageValid_q, stageValid_d;
  logic [PIPE-1:0] stageInv_q, stageInv_d;
  logic [W-1:0]    stageData_q [PIPE];
  logic [W-1:0]    stageData_d [PIPE];
  logic [PIPE-1:0] stageLoad;
  logic [PIPE-1:0] srcValid;
  logic [PIPE-1:0] srcInv;
  logic [W-1:0]    srcData [PIPE];
  logic [CNT_W-1:0] doneCnt_q, doneCnt_d;
  logic             consume;

  // Stall chain: a stage may load when it is empty or everything behind it can move
  always_comb begin
    logic downFree;
    stageLoad = '0;
    downFree  = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      stageLoad[k] = ~stageValid_q[k] | downFree;
      downFree     = stageLoad[k];
    end
  end

  // What each stage would capture: input transform at stage 1, output affine at stage 2, delay after
  always_comb begin
    srcValid[0] = in_valid;
    srcInv[0]   = in_inv;
    if (PIPE == 1) srcData[0] = backWord(frontWord(in_data, in_inv), in_inv);
    else           srcData[0] = frontWord(in_data, in_inv);
    for (int k = 1; k < PIPE; k++) begin
      srcValid[k] = stageValid_q[k-1];
      srcInv[k]   = stageInv_q[k-1];
      if (k == 1) srcData[k] = backWord(stageData_q[k-1], stageInv_q[k-1]);
      else        srcData[k] = stageData_q[k-1];
    end
  end

  // Next stage contents; payload only moves with a valid source so bubbles never overwrite data
  always_comb begin
    stageValid_d = stageValid_q;
    stageInv_d   = stageInv_q;
    for (int k = 0; k < PIPE; k++) begin
      stageData_d[k] = stageData_q[k];
      if (stageLoad[k]) stageValid_d[k] = srcValid[k];
      if (stageLoad[k] && srcValid[k]) begin
        stageData_d[k] = srcData[k];
        stageInv_d[k]  = srcInv[k];
      end
    end
  end

  // Pipeline stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageValid_q <= '0;
      stageInv_q   <= '0;
      for (int k = 0; k < PIPE; k++) stageData_q[k] <= '0;
    end else begin
      stageValid_q <= stageValid_d;
      stageInv_q   <= stageInv_d;
      for (int k = 0; k < PIPE; k++) stageData_q[k] <= stageData_d[k];
    end
  end

  // Completed-transfer counter; clear wins over a coincident consumption
  always_comb begin
    consume   = stageValid_q[PIPE-1] & out_ready;
    doneCnt_d = doneCnt_q;
    if (clr_cnt)      doneCnt_d = '0;
    else if (consume) doneCnt_d = doneCnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) doneCnt_q <= '0;
    else        doneCnt_q <= doneCnt_d;
  end

  assign in_ready  = stageLoad[0];
  assign out_valid = stageValid_q[PIPE-1];
  assign out_inv   = stageInv_q[PIPE-1];
  assign out_data  = stageData_q[PIPE-1];
  assign done_cnt  = doneCnt_q;

`ifdef AES_SBOX_PIPE_PARITY_EN
  logic [LANES-1:0] outPar_q, outPar_d;
  logic [LANES-1:0] lanePar;
  logic [LANES-1:0] inParCalc;
  logic             parErr_q, parErr_d;

  // Output parity follows the data into the last stage; input parity is checked on acceptance
  always_comb begin
    lanePar   = '0;
    inParCalc = '0;
    for (int i = 0; i < LANES; i++) begin
      lanePar[i]   = ^srcData[PIPE-1][8*i +: 8];
      inParCalc[i] = ^in_data[8*i +: 8];
    end
    outPar_d = (stageLoad[PIPE-1] && srcValid[PIPE-1]) ? lanePar : outPar_q;
    parErr_d = parErr_q | (in_valid & stageLoad[0] & (inParCalc != in_par));
  end

  // Parity registers; the error flag is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outPar_q <= '0;
      parErr_q <= 1'b0;
    end else begin
      outPar_q <= outPar_d;
      parErr_q <= parErr_d;
    end
  end

  assign out_par = outPar_q;
  assign par_err = parErr_q;
`endif

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Self-checking bench for aes_sbox_pipe (LANES=4, PIPE=2, CNT_W=4) using a FIPS-197 table
// scoreboard. Parity checks are included when AES_SBOX_PIPE_PARITY_EN is defined.
module tb_aes_sbox_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_inv;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_inv;
  logic [31:0] out_data;
  logic [3:0]  done_cnt;
  logic        clr_cnt;
`ifdef AES_SBOX_PIPE_PARITY_EN
  logic [3:0]  in_par;
  logic [3:0]  out_par;
  logic        par_err;
  logic        parFlip;
`endif

  int   checks;
  int   errors;
  int   accepted;
  int   consumed;
  exp_t sbQueue[$];

  logic [7:0] sboxFwd [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] sboxInv [256];

  aes_sbox_pipe #(.LANES(4), .PIPE(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
`ifdef AES_SBOX_PIPE_PARITY_EN
    .in_par    (in_par),
    .out_par   (out_par),
    .par_err   (par_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inv   (out_inv),
    .out_data  (out_data),
    .done_cnt  (done_cnt),
    .clr_cnt   (clr_cnt)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected substitution of a four-lane word from the reference tables
  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = inv ? sboxInv[d[8*i +: 8]] : sboxFwd[d[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [3:0] laneParity(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  // One comparison: counts it, and reports tag/observed/expected when it does not hold
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // One clock: score the handshakes seen just before the rising edge, return at the falling edge
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checkOutput("scoreboard_nonempty", 32'(sbQueue.size() != 0), 32'd1);
      if (sbQueue.size() != 0) begin
        e = sbQueue.pop_front();
        checkOutput("sb_out_data", out_data, e.data);
        checkOutput("sb_out_inv", 32'(out_inv), 32'(e.inv));
`ifdef AES_SBOX_PIPE_PARITY_EN
        checkOutput("sb_out_par", 32'(out_par), 32'(laneParity(e.data)));
`endif
      end
      consumed++;
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      e.data = model(in_data, in_inv);
      e.inv  = in_inv;
      sbQueue.push_back(e);
      accepted++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one transfer for one clock; the caller decides when to drop in_valid
  task automatic applyStimulus(input logic [31:0] d, input logic inv);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
`ifdef AES_SBOX_PIPE_PARITY_EN
    in_par   = laneParity(d) ^ {3'b000, parFlip};
`endif
    tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && sbQueue.size() != 0; n++) tick();
    checkOutput("drain_timeout", 32'(sbQueue.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          a0;
    int          c0;
    checks    = 0;
    errors    = 0;
    accepted  = 0;
    consumed  = 0;
    for (int i = 0; i < 256; i++) sboxInv[sboxFwd[i]] = 8'(i);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
`ifdef AES_SBOX_PIPE_PARITY_EN
    parFlip   = 1'b0;
    in_par    = '0;
`endif
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_inv", 32'(out_inv), 32'd0);
    checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
`ifdef AES_SBOX_PIPE_PARITY_EN
    checkOutput("rst_par_err", 32'(par_err), 32'd0);
    checkOutput("rst_out_par", 32'(out_par), 32'd0);
`endif
    rst_n = 1'b1;
    #1 checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Forward example with latency check
    applyStimulus(32'h53010000, 1'b0);
    in_valid = 1'b0;
    checkOutput("fwd_not_early", 32'(out_valid), 32'd0);
    tick();
    checkOutput("fwd_valid", 32'(out_valid), 32'd1);
    checkOutput("fwd_data", out_data, 32'hED7C6363);
    checkOutput("fwd_inv", 32'(out_inv), 32'd0);
    tick();
    checkOutput("fwd_done_cnt", 32'(done_cnt), 32'd1);

    // Inverse example
    applyStimulus(32'hED7C6300, 1'b1);
    in_valid = 1'b0;
    tick();
    checkOutput("inv_data", out_data, 32'h53010052);
    checkOutput("inv_inv", 32'(out_inv), 32'd1);
    tick();

    // Exhaustive sweep, forward then inverse, streamed back to back
    a0 = accepted;
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 64; j++) begin
        applyStimulus({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}, m[0]);
      end
    end
    drain();
    checkOutput("sweep_accepted", 32'(accepted - a0), 32'd128);

    // Back-to-back alternating modes: eight results in 8+PIPE cycles
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checkOutput("clr_idle", 32'(done_cnt), 32'd0);
    c0 = consumed;
    for (int i = 0; i < 8; i++) applyStimulus($urandom(), i[0]);
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("b2b_consumed", 32'(consumed - c0), 32'd8);
    checkOutput("b2b_queue_empty", 32'(sbQueue.size()), 32'd0);
    checkOutput("b2b_done_cnt", 32'(done_cnt), 32'd8);

    // Backpressure: five offered, two accepted, output held, then release
    out_ready = 1'b0;
    a0 = accepted;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'hA0B0C0D0 + 32'(i), i[0]);
      if (i == 1) held = out_data;
    end
    #1;
    checkOutput("bp_accepted", 32'(accepted - a0), 32'd2);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_stable", out_data, held);
    checkOutput("bp_head", out_data, model(32'hA0B0C0D0, 1'b0));
    out_ready = 1'b1;
    in_data   = 32'h11223344;
    #1 checkOutput("bp_resume_ready", 32'(in_ready), 32'd1);
    applyStimulus(32'h11223344, 1'b1);
    drain();

    // Counter wrap with CNT_W=4, then clear coincident with consumption
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int i = 0; i < 17; i++) applyStimulus($urandom(), 1'b0);
    drain();
    checkOutput("cnt_wrap", 32'(done_cnt), 32'd1);
    applyStimulus(32'hCAFEF00D, 1'b0);
    in_valid = 1'b0;
    tick();
    checkOutput("clr_pre_valid", 32'(out_valid), 32'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checkOutput("clr_priority", 32'(done_cnt), 32'd0);

    // Reset mid-stream with two transfers in flight
    applyStimulus(32'h01020304, 1'b1);
    drain();
    checkOutput("pre_rst_cnt", 32'(done_cnt), 32'd1);
    out_ready = 1'b0;
    applyStimulus(32'h55667788, 1'b0);
    applyStimulus(32'h99AABBCC, 1'b1);
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_done_cnt", 32'(done_cnt), 32'd0);
    sbQueue.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    checkOutput("post_rst_no_stale", 32'(out_valid), 32'd0);

`ifdef AES_SBOX_PIPE_PARITY_EN
    // Wrong predicted parity sets a sticky error cleared only by reset
    parFlip = 1'b1;
    applyStimulus(32'h0F0F0F0F, 1'b0);
    parFlip = 1'b0;
    in_valid = 1'b0;
    checkOutput("par_err_set", 32'(par_err), 32'd1);
    drain();
    repeat (3) tick();
    checkOutput("par_err_held", 32'(par_err), 32'd1);
    rst_n = 1'b0;
    #1 checkOutput("par_err_rst", 32'(par_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sbox_pipe.md
Name: aes_sbox_pipe

Overview:
- Parametrised, pipelined AES byte-substitution engine; generational successor to the single-byte inverse S-box tile.
- Substitutes LANES bytes per transfer, forward (SubBytes) or inverse (InvSubBytes), selected per transfer.
- Uses valid/ready handshakes on both sides, a configurable pipeline depth with bubble collapse, and a transfer counter.
- Sits between a byte/word source (tile IO adapter or key-schedule sequencer) and the round datapath.

Parameters:
- LANES, 4, bytes substituted per transfer (1..16).
- PIPE, 2, register stages from input to output (1..4).
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input word present.
- in_ready  output  1  engine accepts input this cycle.
- in_inv  input  1  mode for this transfer: 0 = forward S-box, 1 = inverse S-box.
- in_data  input  8*LANES  bytes; lane i = in_data[8i+7:8i].
- out_valid  output  1  result present.
- out_ready  input  1  sink accepts result.
- out_inv  output  1  mode tag travelling with the result.
- out_data  output  8*LANES  substituted bytes, same lane order.
- done_cnt  output  CNT_W  completed output transfers.
- clr_cnt  input  1  synchronous clear of done_cnt.

Behaviour:
- Reset (rst_n=0, async): all stage valid bits 0; out_valid=0; out_data=0; out_inv=0; done_cnt=0. in_ready=1 once reset is released.
- Per-lane function: forward = affine(GF(2^8) inverse(x)); inverse = GF inverse(inv_affine(x)); 0 maps to 0 in the inversion. Results must match FIPS-197 tables for all 256 values in both modes. Implementation may use composite-field logic or ROM; same result either way.
- Pipeline:
  - Stage 1 registers the input transform plus inversion, or the full result when PIPE=1.
  - Stage 2 registers the output affine.
  - Stages 3..PIPE are pure delay.
  - in_inv travels with its data in every stage.
- Latency: accepted at edge t, with no stall, gives out_valid=1 after edge t+PIPE-1, i.e. visible in the cycle following that edge, exactly PIPE cycles after acceptance.
- Stage advance: stage k loads from stage k-1 when stage k is empty or stage k is advancing. The last stage advances when out_valid && out_ready.
- Bubbles collapse: an empty stage is filled even while downstream is stalled.
- in_ready = stage 1 empty OR stage 1 advancing. Combinational from out_ready only through the stall chain; no path from in_valid.
- Transfer accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- Throughput: one transfer per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 holds out_data/out_inv stable; upstream fills, then in_ready=0 once all PIPE stages are full.
- Capacity: exactly PIPE transfers in flight.
- Mixed modes: consecutive transfers may alternate in_inv; each result uses its own tag; no flush required.
- done_cnt increments by 1 on each output consumption and wraps modulo 2^CNT_W.
  - clr_cnt takes priority: when clr_cnt is asserted in the same cycle as a consumption, the result is 0.
- in_data sampled only on acceptance; values while in_ready=0 are ignored.
- Reset mid-operation discards all in-flight transfers; out_valid drops asynchronously.

Optional Feature:
- Macro: AES_SBOX_PIPE_PARITY_EN.
- Defined: extra output out_par, width LANES. Bit i = even parity (XOR) of out_data lane i, registered in the last stage alongside the data; reset value 0.
  - Extra input in_par, width LANES: predicted input parity.
  - Extra output par_err, 1 bit: registered, sticky. Set when an accepted transfer's in_par mismatches the XOR of its in_data lanes; cleared only by reset.
- Undefined: ports out_par, in_par and par_err are absent; no parity logic.

Test Plan:
- Forward, LANES=4, PIPE=2: in_data=0x53_01_00_00, in_inv=0, out_ready=1 -> 2 cycles later out_data=0xED_7C_63_63, out_inv=0, done_cnt=1.
- Inverse: in_data=0xED_7C_63_00, in_inv=1 -> out_data=0x53_01_00_52; then exhaustive sweep of all 256 bytes in both modes must match the FIPS-197 tables.
- Back-to-back alternating mode, 8 transfers, out_ready=1 -> one result per cycle, correct mode per result, done_cnt=8.
- Backpressure: out_ready=0 with 5 offered transfers, PIPE=2 -> exactly 2 accepted, in_ready=0, out_data stable; release out_ready -> both drain in order, and accepts resume the same cycle.
- Counter edges: CNT_W=4, 17 transfers -> done_cnt=1; clr_cnt coincident with consumption -> done_cnt=0.
- Reset mid-stream with 2 in flight -> out_valid=0 immediately, done_cnt=0, no stale output after release. With the parity macro defined: wrong in_par -> par_err=1, held until reset.
